// File: rtl/avg_pkg.sv
// Shared constants and types for the sliding-window averager and its result queue.
package avg_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned WIN_LEN    = 12;
  localparam int unsigned DROP_CNT_W = 16;

  typedef logic [DATA_W-1:0]     sample_t;
  typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

  // Saturating increment used for the dropped-word counter.
  function automatic drop_cnt_t sat_inc(drop_cnt_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/avg_fifo_mem.sv
// Result queue storage: DEPTH x DATA_W, one synchronous write port, one asynchronous read port.
module avg_fifo_mem #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Cleared on reset so the head word reads as zero; flush leaves contents alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/avg_result_fifo.sv
// FWFT result queue behind the averager; drops words offered while full and flags the loss.
// Define AVGQ_DROP_CNT_EN to add the saturating 16-bit drop_cnt output.
module avg_result_fifo #(
  parameter int unsigned DATA_W = avg_pkg::DATA_W,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow
`ifdef AVGQ_DROP_CNT_EN
  ,
  output avg_pkg::drop_cnt_t drop_cnt
`endif
);

  import avg_pkg::*;

  localparam logic [ADDR_W:0] LevelFull = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              push, pop, drop;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LevelFull);
  assign out_valid = ~empty;
  assign level     = level_q;
  assign overflow  = overflow_q;

  assign pop  = out_valid & out_ready;
  // A full queue that is popping this cycle still has room for the incoming word.
  assign push = in_valid & (~full | pop);
  assign drop = in_valid & full & ~pop;

  avg_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push & ~flush),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (out_data)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (drop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef AVGQ_DROP_CNT_EN
  drop_cnt_t drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      drop_cnt_d = '0;
    end else if (drop) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_avg_result_fifo.sv
// Self-checking bench for avg_result_fifo: queue-based reference model plus directed cases.
module tb_avg_result_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          full, empty, overflow;
  logic [AW:0]   level;
`ifdef AVGQ_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avg_result_fifo #(
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow)
`ifdef AVGQ_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  // Reference model: a plain queue plus sticky flag and saturating count.
  logic [DW-1:0] mq[$];
  bit            m_ovf = 0;
  int            m_cnt = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_ovf = 0;
      m_cnt = 0;
    end else if (flush) begin
      mq.delete();
      m_ovf = 0;
      m_cnt = 0;
    end else begin
      bit p_pop, p_push;
      p_pop  = (mq.size() > 0) && out_ready;
      p_push = in_valid && ((mq.size() < DEPTH) || p_pop);
      if (p_pop) void'(mq.pop_front());
      if (p_push) mq.push_back(in_data);
      if (in_valid && !p_push) begin
        m_ovf = 1;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Compare DUT against model every cycle, away from the active edge.
  always @(negedge clk) begin
    check("level", 32'(level), 32'(mq.size()));
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("full", 32'(full), 32'(mq.size() == DEPTH));
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef AVGQ_DROP_CNT_EN
    check("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
`endif
    if (mq.size() != 0) check("out_data", 32'(out_data), 32'(mq[0]));
  end

  // Apply inputs for one cycle starting just after a negedge, return at the next negedge.
  task automatic cyc(input bit iv, input logic [DW-1:0] d, input bit rdy, input bit fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
  endtask

  initial begin
    bit rdy_bias;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1: idle after reset
    check("rst_out_data", 32'(out_data), 32'h0);
    for (int i = 0; i < 10; i++) cyc(0, '0, 1, 0);
    check("t1_empty", 32'(empty), 32'h1);
    check("t1_level", 32'(level), 32'h0);
    check("t1_overflow", 32'(overflow), 32'h0);

    // 2: three pushes then drain in order
    cyc(1, 16'h0005, 0, 0);
    check("t2_latency_valid", 32'(out_valid), 32'h1);
    check("t2_latency_data", 32'(out_data), 32'h5);
    cyc(1, 16'h0006, 0, 0);
    cyc(1, 16'h0007, 0, 0);
    check("t2_level3", 32'(level), 32'h3);
    for (int i = 5; i <= 7; i++) begin
      check("t2_pop_data", 32'(out_data), 32'(i));
      cyc(0, '0, 1, 0);
    end
    check("t2_empty", 32'(empty), 32'h1);

    // 3: overfill, two drops, drain 1..8
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 16'(i), 0, 0);
      if (i == 8) check("t3_full_at_8", 32'(full), 32'h1);
    end
    check("t3_level", 32'(level), 32'h8);
    check("t3_overflow", 32'(overflow), 32'h1);
`ifdef AVGQ_DROP_CNT_EN
    check("t3_drop_cnt", 32'(drop_cnt), 32'h2);
`endif
    for (int i = 1; i <= 8; i++) begin
      check("t3_drain", 32'(out_data), 32'(i));
      cyc(0, '0, 1, 0);
    end
    check("t3_empty", 32'(empty), 32'h1);

    // 4: full with simultaneous push/pop across pointer wrap
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 16'(16'h21 + i), 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 16'(16'h31 + i), 1, 0);
      check("t4_level", 32'(level), 32'h8);
    end
    check("t4_no_drop", 32'(overflow), 32'h0);
    for (int i = 0; i < 8; i++) begin
      check("t4_order", 32'(out_data), (i < 4) ? 32'(16'h25 + i) : 32'(16'h31 + i - 4));
      cyc(0, '0, 1, 0);
    end

    // 5: flush at level 5 with overflow set and a concurrent push
    for (int i = 0; i < 9; i++) cyc(1, 16'(16'h40 + i), 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0);
    check("t5_level5", 32'(level), 32'h5);
    cyc(1, 16'h0099, 0, 1);
    check("t5_level", 32'(level), 32'h0);
    check("t5_empty", 32'(empty), 32'h1);
    check("t5_overflow", 32'(overflow), 32'h0);
    cyc(0, '0, 0, 0);
    check("t5_not_stored", 32'(empty), 32'h1);

    // 6: asynchronous reset between edges at level 6
    for (int i = 0; i < 6; i++) cyc(1, 16'(16'h60 + i), 0, 0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("t6_level", 32'(level), 32'h0);
    check("t6_empty", 32'(empty), 32'h1);
    check("t6_out_valid", 32'(out_valid), 32'h0);
    check("t6_out_data", 32'(out_data), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1, 16'hABCD, 0, 0);
    check("t6_abcd", 32'(out_data), 32'hABCD);
    check("t6_valid", 32'(out_valid), 32'h1);

    // Random traffic, checked every cycle by the compare process
    rdy_bias = 0;
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) rdy_bias = ~rdy_bias;
      cyc($urandom_range(0, 3) != 0, 16'($urandom),
          rdy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
          $urandom_range(0, 63) == 0);
    end
    cyc(0, '0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
